fuel_pump_arbiter: RTL and testbench

FUEL_PUMP_ARBITER -- requirements
Module: fuel_pump_arbiter

---
 rtl/fuel_pump_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fuel_pump_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fuel_pump_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fuel_pump_pkg.sv
// rtl/fuel_pump_pkg.sv - shared state codes, widths and sizing helper for the fuel pump arbiter
package fuel_pump_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_SPINUP   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DISPENSE = 3'd2;
    localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = ST_IDLE,
        S_SPINUP   = ST_SPINUP,
        S_DISPENSE = ST_DISPENSE,
        S_RELEASE  = ST_RELEASE,
        S_FAULT    = ST_FAULT
    } state_t;

    // Bits needed to index 'value' items (or count 0..value-1), never less than one.
    function automatic int count_w(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last served nozzle
module rr_arbiter
    import fuel_pump_pkg::*;
#(
    parameter int NUM_NOZZLES = 4
) (
    input  logic [NUM_NOZZLES-1:0]          req,
    input  logic [count_w(NUM_NOZZLES)-1:0] last_served,
    output logic                            valid,
    output logic [count_w(NUM_NOZZLES)-1:0] index
);

    localparam int IDX_W = count_w(NUM_NOZZLES);

    // One extra bit so last_served + offset never overflows before the wrap.
    logic [IDX_W:0] cand;

    // Walk candidates last+1, last+2, ... with wrap; the first requester wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_NOZZLES; i++) begin
            cand = {1'b0, last_served} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_NOZZLES)) begin
                cand = cand - (IDX_W + 1)'(NUM_NOZZLES);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fuel_pump_arbiter.sv
// rtl/fuel_pump_arbiter.sv - shares one pump motor between nozzles; optional PUMP_TIMEOUT_EN dispense cap with lockout
module fuel_pump_arbiter
    import fuel_pump_pkg::*;
#(
    parameter int NUM_NOZZLES         = 4,
    parameter int SETTLE_CYCLES       = 2,
    parameter int MAX_DISPENSE_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_NOZZLES-1:0]          nozzleSwitch,
    input  logic                            pressureSensor,
    output logic [NUM_NOZZLES-1:0]          fuel_out,
    output logic                            motor_on,
    output logic [count_w(NUM_NOZZLES)-1:0] grant_id,
    output logic [STATE_W-1:0]              State_out
);

    localparam int IDX_W     = count_w(NUM_NOZZLES);
    // One counter serves both spin-up and dispense timing, so size it for the longer.
    localparam int CNT_LIMIT = (SETTLE_CYCLES > MAX_DISPENSE_CYCLES) ? SETTLE_CYCLES : MAX_DISPENSE_CYCLES;
    localparam int CNT_W     = count_w(CNT_LIMIT);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         grant_q;
    logic [IDX_W-1:0]         last_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [NUM_NOZZLES-1:0]   eligible;
    logic                     arb_valid;
    logic [IDX_W-1:0]         arb_index;
    logic                     grant_load;
    logic                     last_load;
    logic                     cnt_clr;
    logic                     cnt_inc;
    logic                     granted_req;

    assign granted_req = nozzleSwitch[grant_q];

`ifdef PUMP_TIMEOUT_EN
    logic [NUM_NOZZLES-1:0]   lock_q;
    logic                     lock_set;

    // A timed-out nozzle stays locked until its handle is seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= '0;
        end else begin
            lock_q <= (lock_q | (lock_set ? (NUM_NOZZLES'(1) << grant_q) : '0)) & nozzleSwitch;
        end
    end

    assign eligible = nozzleSwitch & ~lock_q;
`else
    assign eligible = nozzleSwitch;
`endif

    rr_arbiter #(
        .NUM_NOZZLES (NUM_NOZZLES)
    ) u_rr_arbiter (
        .req         (eligible),
        .last_served (last_q),
        .valid       (arb_valid),
        .index       (arb_index)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; fault beats request drop beats timeout.
    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        last_load  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
`ifdef PUMP_TIMEOUT_EN
        lock_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pressureSensor) begin
                    state_d = S_FAULT;
                end else if (arb_valid) begin
                    state_d    = S_SPINUP;
                    grant_load = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            S_SPINUP: begin
                if (pressureSensor) begin
                    state_d = S_FAULT;
                end else if (!granted_req) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_DISPENSE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DISPENSE: begin
                if (pressureSensor) begin
                    state_d = S_FAULT;
                end else if (!granted_req) begin
                    state_d = S_RELEASE;
                end
`ifdef PUMP_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_DISPENSE_CYCLES - 1)) begin
                    state_d  = S_RELEASE;
                    lock_set = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                last_load = 1'b1;
                state_d   = pressureSensor ? S_FAULT : S_IDLE;
            end
            S_FAULT: begin
                if (!pressureSensor) begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant, round-robin history and the shared timing counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_NOZZLES - 1);
            cnt_q   <= '0;
        end else begin
            if (grant_load) begin
                grant_q <= arb_index;
            end
            if (last_load) begin
                last_q <= grant_q;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Moore outputs decoded from registered state and grant only.
    always_comb begin
        fuel_out = '0;
        if (state_q == S_DISPENSE) begin
            fuel_out[grant_q] = 1'b1;
        end
    end

    assign motor_on  = (state_q == S_SPINUP) || (state_q == S_DISPENSE);
    assign grant_id  = grant_q;
    assign State_out = state_q;

endmodule

// File: tb/tb_fuel_pump_arbiter.sv
// tb/tb_fuel_pump_arbiter.sv - self-checking bench for fuel_pump_arbiter (N=4, SETTLE=2, MAX=8)
module tb_fuel_pump_arbiter;

    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int MAXC   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] nozzleSwitch;
    logic       pressureSensor;
    logic [3:0] fuel_out;
    logic       motor_on;
    logic [1:0] grant_id;
    logic [2:0] State_out;

    int checks = 0;
    int errors = 0;

    // Reference model: spec state codes, time spent in the current state, owner, history, lockouts.
    int         m_st;
    int         m_age;
    int         m_g;
    int         m_last;
    logic [3:0] m_lock;

    typedef struct {
        logic [3:0] sw;
        logic       pr;
        int         st;
        logic [3:0] fuel;
        logic       motor;
        int         grant;
    } vec_t;

    vec_t vecs[17];

    fuel_pump_arbiter #(
        .NUM_NOZZLES         (N),
        .SETTLE_CYCLES       (SETTLE),
        .MAX_DISPENSE_CYCLES (MAXC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .nozzleSwitch   (nozzleSwitch),
        .pressureSensor (pressureSensor),
        .fuel_out       (fuel_out),
        .motor_on       (motor_on),
        .grant_id       (grant_id),
        .State_out      (State_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input int st, input int fuel, input int motor, input int grant);
        check({name, ".state"}, int'(State_out), st);
        check({name, ".fuel"},  int'(fuel_out),  fuel);
        check({name, ".motor"}, int'(motor_on),  motor);
        check({name, ".grant"}, int'(grant_id),  grant);
    endtask

    task automatic model_edge(input logic [3:0] sw, input logic pr, input logic rst);
        int nst;
        int pick;
        int c;
        if (rst) begin
            m_st = 0; m_age = 0; m_g = 0; m_last = N - 1; m_lock = '0;
            return;
        end
        nst = m_st;
        if (m_st == 0) begin
            if (pr) begin
                nst = 4;
            end else begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && sw[c] && !m_lock[c]) pick = c;
                end
                if (pick >= 0) begin
                    nst = 1;
                    m_g = pick;
                end
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (pr) nst = 4;
            else if (!sw[m_g]) nst = 3;
            else if (m_st == 1 && m_age + 1 == SETTLE) nst = 2;
`ifdef PUMP_TIMEOUT_EN
            else if (m_st == 2 && m_age + 1 == MAXC) begin
                nst = 3;
                m_lock[m_g] = 1'b1;
            end
`endif
        end else if (m_st == 3) begin
            m_last = m_g;
            nst = pr ? 4 : 0;
        end else if (m_st == 4) begin
            if (!pr) nst = 3;
        end else begin
            nst = 0;
        end
        m_lock = m_lock & sw;
        m_age  = (nst == m_st) ? m_age + 1 : 0;
        m_st   = nst;
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
    task automatic step(input logic [3:0] sw, input logic pr, input logic rst);
        nozzleSwitch   = sw;
        pressureSensor = pr;
        reset          = rst;
        @(posedge clk);
        model_edge(sw, pr, rst);
        #1;
    endtask

    task automatic check_model(input string name);
        check_outs(name, m_st, (m_st == 2) ? (1 << m_g) : 0, (m_st == 1 || m_st == 2) ? 1 : 0, m_g);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rsw;
        logic       rpr;
        logic       rrst;
        logic [3:0] held;
        int         exp_order[5];

        // Single request, fault with simultaneous drop, fault in IDLE with requests pending.
        vecs[0]  = '{4'b0001, 1'b0, 1, 4'b0000, 1'b1, 0};
        vecs[1]  = '{4'b0001, 1'b0, 1, 4'b0000, 1'b1, 0};
        vecs[2]  = '{4'b0001, 1'b0, 2, 4'b0001, 1'b1, 0};
        vecs[3]  = '{4'b0001, 1'b0, 2, 4'b0001, 1'b1, 0};
        vecs[4]  = '{4'b0000, 1'b0, 3, 4'b0000, 1'b0, 0};
        vecs[5]  = '{4'b0000, 1'b0, 0, 4'b0000, 1'b0, 0};
        vecs[6]  = '{4'b0010, 1'b0, 1, 4'b0000, 1'b1, 1};
        vecs[7]  = '{4'b0010, 1'b0, 1, 4'b0000, 1'b1, 1};
        vecs[8]  = '{4'b0010, 1'b0, 2, 4'b0010, 1'b1, 1};
        vecs[9]  = '{4'b0000, 1'b1, 4, 4'b0000, 1'b0, 1};
        vecs[10] = '{4'b0000, 1'b1, 4, 4'b0000, 1'b0, 1};
        vecs[11] = '{4'b0000, 1'b0, 3, 4'b0000, 1'b0, 1};
        vecs[12] = '{4'b0000, 1'b0, 0, 4'b0000, 1'b0, 1};
        vecs[13] = '{4'b1111, 1'b1, 4, 4'b0000, 1'b0, 1};
        vecs[14] = '{4'b1111, 1'b0, 3, 4'b0000, 1'b0, 1};
        vecs[15] = '{4'b1111, 1'b0, 0, 4'b0000, 1'b0, 1};
        vecs[16] = '{4'b1111, 1'b0, 1, 4'b0000, 1'b1, 2};

        nozzleSwitch = '0; pressureSensor = 1'b0; reset = 1'b1;
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        check_outs("reset", 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].sw, vecs[i].pr, 1'b0);
            check_outs($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].fuel), int'(vecs[i].motor), vecs[i].grant);
        end

        // Round-robin with all handles held, each owner releasing in turn.
        step(4'b0000, 1'b0, 1'b1);
        exp_order = '{0, 1, 2, 3, 0};
        held = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 10 && State_out != 3'd2; w++) step(held, 1'b0, 1'b0);
            check($sformatf("rr%0d.dispense", r), int'(State_out), 2);
            check($sformatf("rr%0d.grant", r), int'(grant_id), exp_order[r]);
            step(held & ~(4'b0001 << grant_id), 1'b0, 1'b0);
            check($sformatf("rr%0d.release", r), int'(State_out), 3);
            step(held, 1'b0, 1'b0);
        end

        // Reset in the middle of a dispense restores nozzle 0 priority.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check_outs("pre_reset", 2, 4, 1, 2);
        step(4'b1111, 1'b0, 1'b1);
        check_outs("mid_reset", 0, 0, 0, 0);
        step(4'b1111, 1'b0, 1'b0);
        check_outs("post_reset", 1, 0, 1, 0);

`ifdef PUMP_TIMEOUT_EN
        // Dispense cap, lockout of nozzle 2, nozzle 3 served meanwhile, unlock on release.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
        check_outs("to.dispense", 2, 4, 1, 2);
        for (int i = 0; i < 7; i++) step(4'b0100, 1'b0, 1'b0);
        check("to.still_dispensing", int'(State_out), 2);
        step(4'b0100, 1'b0, 1'b0);
        check("to.timeout_release", int'(State_out), 3);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("to.locked_idle", int'(State_out), 0);
        step(4'b1100, 1'b0, 1'b0);
        check_outs("to.serve3", 1, 0, 1, 3);
        step(4'b1100, 1'b0, 1'b0);
        step(4'b1100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("to.still_locked", int'(State_out), 0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check_outs("to.unlocked", 1, 0, 1, 2);
`endif

        // Randomized traffic against the reference model.
        step(4'b0000, 1'b0, 1'b1);
        rsw = '0; rpr = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 5) == 0) rsw[$urandom_range(0, 3)] ^= 1'b1;
            if (rpr) begin
                if ($urandom_range(0, 3) == 0) rpr = 1'b0;
            end else begin
                if ($urandom_range(0, 59) == 0) rpr = 1'b1;
            end
            rrst = ($urandom_range(0, 199) == 0);
            step(rsw, rpr, rrst);
            check_model($sformatf("rand%0d", cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
